// File: rtl/intp_ctrl_pkg.sv
// Shared types and constants for the priority interrupt controller.
// Holds the FSM state encoding and the reset value of every priority register.
package intp_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } intp_state_t;

  localparam int DEFAULT_PRIO = 0;

endpackage

// File: rtl/intp_prio_arbiter.sv
// Combinational max-priority search over the active mask; ties go to the lowest index.
// Zero latency, no flow control; the result is meaningless when the mask is all zero.
module intp_prio_arbiter #(
  parameter int NUM_SRC    = 16,
  parameter int IDX_WIDTH  = 4,
  parameter int PRIO_WIDTH = 4
) (
  input  logic [NUM_SRC-1:0]            active,
  input  logic [NUM_SRC*PRIO_WIDTH-1:0] prio_flat,
  output logic [IDX_WIDTH-1:0]          winner
);

  logic [PRIO_WIDTH-1:0] best_prio;
  logic                  found;

  // Strict greater-than keeps the earlier (lower) index on equal priorities.
  always_comb begin
    best_prio = '0;
    found     = 1'b0;
    winner    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active[i] && (!found || (prio_flat[i*PRIO_WIDTH +: PRIO_WIDTH] > best_prio))) begin
        best_prio = prio_flat[i*PRIO_WIDTH +: PRIO_WIDTH];
        winner    = IDX_WIDTH'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intp_ctrl_core.sv
// APB-programmable priority interrupt controller: presents the highest-priority pending source.
// Valid one cycle after a line rises in IDLE; held until serviced; APB has zero wait states.
module intp_ctrl_core
  import intp_ctrl_pkg::*;
#(
  parameter int NUM_OF_PERIPHERALS = 16,
  parameter int ADDR_WIDTH         = 4,
  parameter int DATA_WIDTH         = 4
) (
  input  logic                          pclk_i,
  input  logic                          prst_i,
  input  logic [ADDR_WIDTH-1:0]         paddr_i,
  input  logic                          pwrite_i,
  input  logic [DATA_WIDTH-1:0]         pwdata_i,
  input  logic                          penable_i,
  output logic [DATA_WIDTH-1:0]         prdata_o,
  output logic                          pready_o,
  output logic                          perror_o,
  input  logic [NUM_OF_PERIPHERALS-1:0] intp_active_i,
  input  logic                          intp_serviced_i,
  output logic                          intp_valid_o,
  output logic [ADDR_WIDTH-1:0]         intp_to_service_o
);

  logic [DATA_WIDTH-1:0]                    prio_q [NUM_OF_PERIPHERALS];
  logic [NUM_OF_PERIPHERALS*DATA_WIDTH-1:0] prio_flat;
  logic [ADDR_WIDTH-1:0]                    winner;
  logic                                     addr_err;
  logic                                     wr_en;
  intp_state_t                              state_q;

  assign addr_err = ({1'b0, paddr_i} >= (ADDR_WIDTH+1)'(NUM_OF_PERIPHERALS));
  assign wr_en    = penable_i && pwrite_i && !addr_err;

  assign pready_o = penable_i;
  assign perror_o = penable_i && addr_err;
  assign prdata_o = (penable_i && !pwrite_i && !addr_err) ? prio_q[paddr_i] : '0;

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      for (int i = 0; i < NUM_OF_PERIPHERALS; i++) begin
        prio_q[i] <= DATA_WIDTH'(DEFAULT_PRIO);
      end
    end else if (wr_en) begin
      prio_q[paddr_i] <= pwdata_i;
    end
  end

  always_comb begin
    prio_flat = '0;
    for (int i = 0; i < NUM_OF_PERIPHERALS; i++) begin
      prio_flat[i*DATA_WIDTH +: DATA_WIDTH] = prio_q[i];
    end
  end

  // Arbitration sees the registered priorities, so a same-cycle write lands after the pick.
  intp_prio_arbiter #(
    .NUM_SRC    (NUM_OF_PERIPHERALS),
    .IDX_WIDTH  (ADDR_WIDTH),
    .PRIO_WIDTH (DATA_WIDTH)
  ) u_arbiter (
    .active    (intp_active_i),
    .prio_flat (prio_flat),
    .winner    (winner)
  );

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state_q           <= IDLE;
      intp_valid_o      <= 1'b0;
      intp_to_service_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|intp_active_i) begin
            intp_to_service_o <= winner;
            intp_valid_o      <= 1'b1;
            state_q           <= SERVICE;
          end else begin
            intp_to_service_o <= '0;
            intp_valid_o      <= 1'b0;
          end
        end
        SERVICE: begin
          // Presented request is frozen until acknowledged, whatever the lines do.
          if (intp_serviced_i) begin
            intp_to_service_o <= '0;
            intp_valid_o      <= 1'b0;
            state_q           <= IDLE;
          end
        end
        default: begin
          intp_to_service_o <= '0;
          intp_valid_o      <= 1'b0;
          state_q           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intp_ctrl_core.sv
// Self-checking bench for intp_ctrl_core: directed tables, corner sequences, random vs. model.
module tb_intp_ctrl_core;

  logic        pclk_i = 1'b0;
  logic        prst_i;
  logic [3:0]  paddr_i;
  logic        pwrite_i;
  logic [3:0]  pwdata_i;
  logic        penable_i;
  logic [3:0]  prdata_o;
  logic        pready_o;
  logic        perror_o;
  logic [15:0] intp_active_i;
  logic        intp_serviced_i;
  logic        intp_valid_o;
  logic [3:0]  intp_to_service_o;

  intp_ctrl_core dut (
    .pclk_i            (pclk_i),
    .prst_i            (prst_i),
    .paddr_i           (paddr_i),
    .pwrite_i          (pwrite_i),
    .pwdata_i          (pwdata_i),
    .penable_i         (penable_i),
    .prdata_o          (prdata_o),
    .pready_o          (pready_o),
    .perror_o          (perror_o),
    .intp_active_i     (intp_active_i),
    .intp_serviced_i   (intp_serviced_i),
    .intp_valid_o      (intp_valid_o),
    .intp_to_service_o (intp_to_service_o)
  );

  initial forever #5 pclk_i = ~pclk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_prio [16];
  bit m_valid;
  int m_idx;

  typedef struct {
    logic [15:0] active;
    int          exp_idx;
  } arb_vec_t;

  arb_vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input logic [15:0] act);
    int best = -1;
    for (int i = 0; i < 16; i++)
      if (act[i] && m_prio[i] > best) best = m_prio[i];
    for (int i = 0; i < 16; i++)
      if (act[i] && m_prio[i] == best) return i;
    return 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_prio[i] = 0;
    m_valid = 1'b0;
    m_idx   = 0;
  endfunction

  // Called at a negedge with this cycle's inputs applied; checks outputs after the edge.
  task automatic tick();
    if (m_valid) begin
      if (intp_serviced_i) begin
        m_valid = 1'b0;
        m_idx   = 0;
      end
    end else if (intp_active_i != 16'h0) begin
      m_idx   = pick(intp_active_i);
      m_valid = 1'b1;
    end
    if (penable_i && pwrite_i) m_prio[paddr_i] = int'(pwdata_i);
    @(posedge pclk_i);
    @(negedge pclk_i);
    check("valid", int'(intp_valid_o), int'(m_valid));
    check("to_service", int'(intp_to_service_o), m_idx);
  endtask

  task automatic idle_bus();
    penable_i = 1'b0;
    pwrite_i  = 1'b0;
    paddr_i   = '0;
    pwdata_i  = '0;
  endtask

  task automatic apb_write(input int addr, input int data);
    penable_i = 1'b1;
    pwrite_i  = 1'b1;
    paddr_i   = 4'(addr);
    pwdata_i  = 4'(data);
    #1;
    check("wr_pready", int'(pready_o), 1);
    check("wr_perror", int'(perror_o), 0);
    tick();
    idle_bus();
  endtask

  task automatic apb_read(input int addr, input int exp);
    penable_i = 1'b1;
    pwrite_i  = 1'b0;
    paddr_i   = 4'(addr);
    #1;
    check("rd_data", int'(prdata_o), exp);
    check("rd_pready", int'(pready_o), 1);
    check("rd_perror", int'(perror_o), 0);
    idle_bus();
    #1;
    check("rd_idle_zero", int'(prdata_o), 0);
  endtask

  task automatic service();
    intp_active_i   = '0;
    intp_serviced_i = 1'b1;
    tick();
    intp_serviced_i = 1'b0;
  endtask

  task automatic do_reset();
    prst_i = 1'b0;
    model_reset();
    repeat (2) @(negedge pclk_i);
    check("rst_valid", int'(intp_valid_o), 0);
    check("rst_idx", int'(intp_to_service_o), 0);
    check("rst_prdata", int'(prdata_o), 0);
    check("rst_pready", int'(pready_o), 0);
    check("rst_perror", int'(perror_o), 0);
    prst_i = 1'b1;
  endtask

  initial begin
    prst_i          = 1'b0;
    intp_active_i   = '0;
    intp_serviced_i = 1'b0;
    idle_bus();
    @(negedge pclk_i);

    // 1. Reset
    do_reset();
    for (int i = 0; i < 16; i++) apb_read(i, 0);

    // 2. Write prio[i] = 15-i and read back
    for (int i = 0; i < 16; i++) apb_write(i, 15 - i);
    for (int i = 0; i < 16; i++) apb_read(i, 15 - i);

    // 3. Table: with prio[i] = 15-i the lowest active index wins
    vecs[0] = '{16'h0010, 4};
    vecs[1] = '{16'h8001, 0};
    vecs[2] = '{16'hF000, 12};
    vecs[3] = '{16'h0100, 8};
    vecs[4] = '{16'h8000, 15};
    vecs[5] = '{16'h0A60, 5};
    for (int v = 0; v < 6; v++) begin
      intp_active_i = vecs[v].active;
      tick();
      check("tbl_valid", int'(intp_valid_o), 1);
      check("tbl_idx", int'(intp_to_service_o), vecs[v].exp_idx);
      service();
      check("tbl_cleared", int'(intp_valid_o), 0);
    end

    // Serviced in IDLE is ignored
    intp_serviced_i = 1'b1;
    tick();
    intp_serviced_i = 1'b0;
    check("idle_serviced", int'(intp_valid_o), 0);

    // 4. Priority pick then fallback after one IDLE cycle
    apb_write(3, 9);
    apb_write(7, 12);
    intp_active_i = 16'h0088;
    tick();
    check("pick7", int'(intp_to_service_o), 7);
    intp_active_i   = 16'h0008;
    intp_serviced_i = 1'b1;
    tick();
    check("gap_idle", int'(intp_valid_o), 0);
    intp_serviced_i = 1'b0;
    tick();
    check("pick3_valid", int'(intp_valid_o), 1);
    check("pick3", int'(intp_to_service_o), 3);
    service();

    // 5. Tie goes to lowest index
    apb_write(2, 6);
    apb_write(5, 6);
    intp_active_i = 16'h0024;
    tick();
    check("tie", int'(intp_to_service_o), 2);
    service();

    // Same-cycle write: arbitration uses pre-write priority (prio[3]=9 > prio[5]=6)
    intp_active_i = 16'h0028;
    penable_i = 1'b1; pwrite_i = 1'b1; paddr_i = 4'd5; pwdata_i = 4'd15;
    tick();
    idle_bus();
    check("prewrite_pick", int'(intp_to_service_o), 3);
    apb_read(5, 15);

    // 6. Hold in SERVICE despite line and priority changes
    intp_active_i = 16'h0020;
    apb_write(3, 0);
    check("hold_idx", int'(intp_to_service_o), 3);
    intp_active_i = 16'h0000;
    tick();
    check("hold_valid", int'(intp_valid_o), 1);

    // Asynchronous reset mid-cycle drops valid immediately
    #2 prst_i = 1'b0;
    #1;
    check("async_valid", int'(intp_valid_o), 0);
    check("async_idx", int'(intp_to_service_o), 0);
    @(negedge pclk_i);
    do_reset();
    for (int i = 0; i < 16; i++) apb_read(i, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      intp_active_i   = 16'($urandom & $urandom & $urandom);
      intp_serviced_i = ($urandom_range(0, 2) == 0);
      idle_bus();
      case ($urandom_range(0, 3))
        0: begin
          penable_i = 1'b1; pwrite_i = 1'b1;
          paddr_i = 4'($urandom); pwdata_i = 4'($urandom);
        end
        1: begin
          penable_i = 1'b1; pwrite_i = 1'b0; paddr_i = 4'($urandom);
          #1;
          check("rnd_rd", int'(prdata_o), m_prio[paddr_i]);
          check("rnd_perror", int'(perror_o), 0);
        end
        default: ;
      endcase
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
